// File: rtl/mem_refill_arbiter_if.sv
// Bundle of the cache-miss and main-memory read signals around the refill arbiter.
// The arbiter connects through 'master'; caches and memory (or a bench) use 'slave'.
interface mem_refill_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 64
);
  logic               I_MISS;
  logic [ADDR_W-1:0]  I_ADDR;
  logic               I_FILL;
  logic [BLOCK_W-1:0] I_DATA;
  logic               D_MISS;
  logic [ADDR_W-1:0]  D_ADDR;
  logic               D_FILL;
  logic [BLOCK_W-1:0] D_DATA;
  logic               MM_REQ;
  logic [ADDR_W-1:0]  MM_ADDR;
  logic               MM_ACK;
  logic [BLOCK_W-1:0] MM_RDATA;

  modport master (
    input  I_MISS, I_ADDR, D_MISS, D_ADDR, MM_ACK, MM_RDATA,
    output I_FILL, I_DATA, D_FILL, D_DATA, MM_REQ, MM_ADDR
  );

  modport slave (
    output I_MISS, I_ADDR, D_MISS, D_ADDR, MM_ACK, MM_RDATA,
    input  I_FILL, I_DATA, D_FILL, D_DATA, MM_REQ, MM_ADDR
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one main-memory read port between the I-cache and
// D-cache refill paths. One transaction outstanding: IDLE -> REQ -> FILL -> HOLD.
// A request with no ack for TIMEOUT_CYC cycles is aborted. Keeps saturating stats.
module mem_refill_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_W     = 64,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 20
) (
  input  logic                CLK,
  input  logic                RESET,
  mem_refill_arbiter_if.master bus,
  output logic                BUSY,
  output logic                GRANT_D,
  output logic                TIMEOUT_ERR,
  output logic [CNT_W-1:0]    CNT_I_REFILL,
  output logic [CNT_W-1:0]    CNT_D_REFILL,
  output logic [CNT_W-1:0]    CNT_TIMEOUT
);

  localparam int              TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               mm_req_q, mm_req_d;
  logic [ADDR_W-1:0]  mm_addr_q, mm_addr_d;
  logic               i_fill_q, i_fill_d;
  logic               d_fill_q, d_fill_d;
  logic [BLOCK_W-1:0] i_data_q, i_data_d;
  logic [BLOCK_W-1:0] d_data_q, d_data_d;
  logic               grant_d_q, grant_d_d;
  logic               last_grant_q, last_grant_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0]   cnt_d_q, cnt_d_d;
  logic [CNT_W-1:0]   cnt_t_q, cnt_t_d;
  logic               win_d;
  logic [ADDR_W-1:0]  win_addr;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d       = state_q;
    mm_req_d      = mm_req_q;
    mm_addr_d     = mm_addr_q;
    i_fill_d      = 1'b0;
    d_fill_d      = 1'b0;
    i_data_d      = i_data_q;
    d_data_d      = d_data_q;
    grant_d_d     = grant_d_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
    cnt_i_d       = cnt_i_q;
    cnt_d_d       = cnt_d_q;
    cnt_t_d       = cnt_t_q;
    // D wins when it is the only requester, or on a tie when I went last.
    win_d         = bus.D_MISS && (!bus.I_MISS || !last_grant_q);
    win_addr      = win_d ? bus.D_ADDR : bus.I_ADDR;

    case (state_q)
      S_IDLE: begin
        if (bus.I_MISS || bus.D_MISS) begin
          grant_d_d    = win_d;
          last_grant_d = win_d;
          mm_addr_d    = {win_addr[ADDR_W-1:3], 3'b000};
          mm_req_d     = 1'b1;
          timer_d      = '0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.MM_ACK) begin
          if (grant_d_q) begin
            d_data_d = bus.MM_RDATA;
            d_fill_d = 1'b1;
            cnt_d_d  = sat_inc(cnt_d_q);
          end else begin
            i_data_d = bus.MM_RDATA;
            i_fill_d = 1'b1;
            cnt_i_d  = sat_inc(cnt_i_q);
          end
          mm_req_d = 1'b0;
          state_d  = S_FILL;
        end else if (timer_q == TMR_LAST) begin
          mm_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          cnt_t_d       = sat_inc(cnt_t_q);
          state_d       = S_HOLD;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      // Fill strobe is visible during this state; nothing else to do.
      S_FILL:  state_d = S_HOLD;
      // Dead cycle lets the cache drop its miss before we arbitrate again.
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      mm_req_q      <= 1'b0;
      mm_addr_q     <= '0;
      i_fill_q      <= 1'b0;
      d_fill_q      <= 1'b0;
      i_data_q      <= '0;
      d_data_q      <= '0;
      grant_d_q     <= 1'b0;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_i_q       <= '0;
      cnt_d_q       <= '0;
      cnt_t_q       <= '0;
    end else begin
      state_q       <= state_d;
      mm_req_q      <= mm_req_d;
      mm_addr_q     <= mm_addr_d;
      i_fill_q      <= i_fill_d;
      d_fill_q      <= d_fill_d;
      i_data_q      <= i_data_d;
      d_data_q      <= d_data_d;
      grant_d_q     <= grant_d_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_i_q       <= cnt_i_d;
      cnt_d_q       <= cnt_d_d;
      cnt_t_q       <= cnt_t_d;
    end
  end

  assign bus.MM_REQ   = mm_req_q;
  assign bus.MM_ADDR  = mm_addr_q;
  assign bus.I_FILL   = i_fill_q;
  assign bus.I_DATA   = i_data_q;
  assign bus.D_FILL   = d_fill_q;
  assign bus.D_DATA   = d_data_q;
  assign BUSY         = busy_q;
  assign GRANT_D      = grant_d_q;
  assign TIMEOUT_ERR  = timeout_err_q;
  assign CNT_I_REFILL = cnt_i_q;
  assign CNT_D_REFILL = cnt_d_q;
  assign CNT_TIMEOUT  = cnt_t_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: a directed vector table, hand sequences for
// reset / spurious ack / timeout corners, and randomized transactions checked
// against a transaction-level model (round-robin owner, counts, last blocks).
module tb_mem_refill_arbiter;
  localparam int AW   = 32;
  localparam int BW   = 64;
  localparam int TOC  = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          BUSY, GRANT_D, TIMEOUT_ERR;
  logic [CW-1:0] CNT_I_REFILL, CNT_D_REFILL, CNT_TIMEOUT;

  mem_refill_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

  mem_refill_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT_CYC(TOC), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .BUSY(BUSY), .GRANT_D(GRANT_D), .TIMEOUT_ERR(TIMEOUT_ERR),
    .CNT_I_REFILL(CNT_I_REFILL), .CNT_D_REFILL(CNT_D_REFILL), .CNT_TIMEOUT(CNT_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          n_i, n_d, n_t;
  bit          last_d;
  logic [63:0] m_i_data, m_d_data;
  int          earliest;

  typedef struct {
    bit          im;
    bit          dm;
    logic [31:0] ia;
    logic [31:0] da;
    int          k;       // ack delay in cycles after MM_REQ rises, -1 = never
    logic [63:0] rd;
    bit          exp_d;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, "_cnt_i"}, 64'(CNT_I_REFILL), 64'(sat(n_i)));
    chk({tag, "_cnt_d"}, 64'(CNT_D_REFILL), 64'(sat(n_d)));
    chk({tag, "_cnt_t"}, 64'(CNT_TIMEOUT),  64'(sat(n_t)));
  endtask

  task automatic check_data(input string tag);
    chk({tag, "_i_data"}, bus.I_DATA, m_i_data);
    chk({tag, "_d_data"}, bus.D_DATA, m_d_data);
  endtask

  task automatic model_reset();
    n_i = 0; n_d = 0; n_t = 0;
    last_d = 1'b1;
    m_i_data = '0; m_d_data = '0;
    earliest = 0;
  endtask

  task automatic do_reset();
    bus.I_MISS = 1'b0; bus.D_MISS = 1'b0; bus.MM_ACK = 1'b0;
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_mm_req", 64'(bus.MM_REQ), 64'(0));
    chk("rst_mm_addr", 64'(bus.MM_ADDR), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_grant", 64'(GRANT_D), 64'(0));
    chk("rst_err", 64'(TIMEOUT_ERR), 64'(0));
    chk("rst_fills", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
    check_counters("rst");
    check_data("rst");
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wiggle_inputs(input bit en);
    if (en) begin
      bus.I_ADDR = $urandom;
      bus.D_ADDR = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        bus.I_MISS = 1'b0;
        bus.D_MISS = 1'b0;
      end
    end
  endtask

  // One full refill (or aborted) transaction; returns during the HOLD cycle.
  task automatic run_txn(input bit im, input bit dm, input logic [31:0] ia, input logic [31:0] da,
                         input int k, input logic [63:0] rd, input bit exp_d,
                         input logic [31:0] exp_addr, input bit wiggle);
    int c_drive, rise, exp_rise, req_cycles;
    bus.I_MISS = im; bus.D_MISS = dm; bus.I_ADDR = ia; bus.D_ADDR = da;
    c_drive = cyc;
    for (int w = 0; w < 12 && !bus.MM_REQ; w++) begin
      @(posedge CLK); #1;
    end
    if (!bus.MM_REQ) begin
      chk("req_rise_timeout", 64'(0), 64'(1));
      return;
    end
    rise     = cyc;
    exp_rise = (c_drive + 1 > earliest) ? c_drive + 1 : earliest;
    chk("req_latency", 64'(rise), 64'(exp_rise));
    chk("grant", 64'(GRANT_D), 64'(exp_d));
    chk("mm_addr", 64'(bus.MM_ADDR), 64'(exp_addr));
    chk("busy_req", 64'(BUSY), 64'(1));
    last_d = exp_d;

    if (k >= 0) begin
      for (int j = 0; j < k; j++) begin
        wiggle_inputs(wiggle);
        @(posedge CLK); #1;
        chk("req_held", 64'(bus.MM_REQ), 64'(1));
        chk("addr_held", 64'(bus.MM_ADDR), 64'(exp_addr));
      end
      bus.MM_ACK = 1'b1; bus.MM_RDATA = rd;
      @(posedge CLK); #1;
      bus.MM_ACK = 1'b0; bus.MM_RDATA = {$urandom, $urandom};
      if (exp_d) begin n_d++; m_d_data = rd; end
      else       begin n_i++; m_i_data = rd; end
      chk("i_fill", 64'(bus.I_FILL), 64'(!exp_d));
      chk("d_fill", 64'(bus.D_FILL), 64'(exp_d));
      chk("req_drop", 64'(bus.MM_REQ), 64'(0));
      chk("grant_fill", 64'(GRANT_D), 64'(exp_d));
      check_data("fill");
      check_counters("fill");
      earliest = cyc + 3;
      @(posedge CLK); #1;
      chk("fill_pulse", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
      chk("busy_hold", 64'(BUSY), 64'(1));
    end else begin
      req_cycles = 1;
      for (int w = 0; w < TOC + 4 && !TIMEOUT_ERR; w++) begin
        wiggle_inputs(wiggle);
        @(posedge CLK); #1;
        if (bus.MM_REQ) req_cycles++;
        if (!TIMEOUT_ERR) chk("addr_held_to", 64'(bus.MM_ADDR), 64'(exp_addr));
      end
      n_t++;
      chk("timeout_seen", 64'(TIMEOUT_ERR), 64'(1));
      chk("req_cycles", 64'(req_cycles), 64'(TOC));
      chk("abort_time", 64'(cyc - rise), 64'(TOC));
      chk("to_fills", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
      check_data("to");
      check_counters("to");
      earliest = cyc + 2;
      @(posedge CLK); #1;
      chk("err_pulse", 64'(TIMEOUT_ERR), 64'(0));
      chk("to_fills2", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          im, dm, own;
    logic [31:0] ia, da;
    int          k;
    int          w;

    bus.I_MISS = 1'b0; bus.D_MISS = 1'b0; bus.I_ADDR = '0; bus.D_ADDR = '0;
    bus.MM_ACK = 1'b0; bus.MM_RDATA = '0;

    // Starting right after reset, last_grant=1 so the first tie goes to I.
    vecs[0] = '{1'b1, 1'b1, 32'h1000_0004, 32'h2000_000C, 0, 64'h1111_2222_3333_4444, 1'b0, 32'h1000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h1000_0018, 32'h2000_0027, 2, 64'h5555_6666_7777_8888, 1'b1, 32'h2000_0020};
    vecs[2] = '{1'b1, 1'b1, 32'h1000_0031, 32'h2000_0040, 1, 64'h9999_AAAA_BBBB_CCCC, 1'b0, 32'h1000_0030};
    vecs[3] = '{1'b1, 1'b1, 32'h1000_0047, 32'h2000_005F, 5, 64'hDDDD_EEEE_FFFF_0000, 1'b1, 32'h2000_0058};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0ABC, -1, 64'h0,                 1'b1, 32'h0000_0AB8};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 3, 64'h0123_4567_89AB_CDEF, 1'b0, 32'hFFFF_FFF8};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, -1, 64'h0,                 1'b0, 32'h0000_0000};
    vecs[7] = '{1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321, 0, 64'hFEDC_BA98_7654_3210, 1'b1, 32'h8765_4320};

    do_reset();
    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].im, vecs[i].dm, vecs[i].ia, vecs[i].da, vecs[i].k,
              vecs[i].rd, vecs[i].exp_d, vecs[i].exp_addr, 1'b0);
    bus.I_MISS = 1'b0; bus.D_MISS = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Reset in the middle of REQ, then a late ack that must be ignored.
    bus.D_MISS = 1'b1; bus.D_ADDR = 32'h0000_3004;
    w = 0;
    while (!bus.MM_REQ && w < 12) begin @(posedge CLK); #1; w++; end
    chk("rst_mid_req_up", 64'(bus.MM_REQ), 64'(1));
    bus.D_MISS = 1'b0;
    #3 RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_mm_req", 64'(bus.MM_REQ), 64'(0));
    chk("rst_mid_busy", 64'(BUSY), 64'(0));
    check_counters("rst_mid");
    @(negedge CLK);
    RESET = 1'b0;
    bus.MM_ACK = 1'b1; bus.MM_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge CLK); #1;
    bus.MM_ACK = 1'b0;
    chk("late_ack_fills", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
    chk("late_ack_busy", 64'(BUSY), 64'(0));
    chk("late_ack_req", 64'(bus.MM_REQ), 64'(0));
    check_data("late_ack");
    check_counters("late_ack");

    // Single I miss at 0x44, ack three cycles after the request.
    run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 3, 64'hAAAA_0001_BBBB_0002, 1'b0, 32'h0000_0040, 1'b0);

    // Spurious ack during HOLD, then during IDLE.
    bus.I_MISS = 1'b0;
    bus.MM_ACK = 1'b1; bus.MM_RDATA = 64'h5A5A_5A5A_5A5A_5A5A;
    @(posedge CLK); #1;
    bus.MM_ACK = 1'b0;
    chk("hold_ack_fills", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
    chk("hold_ack_busy", 64'(BUSY), 64'(0));
    check_data("hold_ack");
    check_counters("hold_ack");
    bus.MM_ACK = 1'b1; bus.MM_RDATA = 64'hA5A5_A5A5_A5A5_A5A5;
    @(posedge CLK); #1;
    bus.MM_ACK = 1'b0;
    @(posedge CLK); #1;
    chk("idle_ack_fills", 64'({bus.I_FILL, bus.D_FILL}), 64'(0));
    chk("idle_ack_busy", 64'(BUSY), 64'(0));
    chk("idle_ack_req", 64'(bus.MM_REQ), 64'(0));
    check_data("idle_ack");
    check_counters("idle_ack");

    // Random transactions; enough refills to drive the counters into saturation.
    for (int t = 0; t < 70; t++) begin
      im = 1'b0; dm = 1'b0;
      while (!im && !dm) begin
        im = 1'($urandom_range(0, 1));
        dm = 1'($urandom_range(0, 1));
      end
      own = (im && dm) ? !last_d : dm;
      ia  = $urandom;
      da  = $urandom;
      k   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn(im, dm, ia, da, k, {$urandom, $urandom}, own,
              {(own ? da[31:3] : ia[31:3]), 3'b000}, 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        bus.I_MISS = 1'b0; bus.D_MISS = 1'b0;
        repeat ($urandom_range(2, 5)) @(posedge CLK);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
